// File: rtl/ray_worker_multi.sv
// ray_worker_multi: renders a strip of pixels against several spheres, keeps the nearest hit and streams colours out
module ray_worker_multi #(
  parameter int N_SPHERES = 4,
  parameter int JOBS = 64,
  parameter int STRIDE = 10,
  parameter int PZ = 320,
  parameter int COORD_W = 12,
  parameter int SPH_W = 16,
  parameter int COLOR_W = 12,
  parameter logic [COLOR_W-1:0] BG_COLOR = 12'h000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [COORD_W-1:0]             pixel_start_x,
  input  logic [COORD_W-1:0]             pixel_y,
  input  logic [N_SPHERES*SPH_W-1:0]     sphere_x,
  input  logic [N_SPHERES*SPH_W-1:0]     sphere_y,
  input  logic [N_SPHERES*SPH_W-1:0]     sphere_z,
  input  logic [N_SPHERES*4-1:0]         sphere_r,
  input  logic [N_SPHERES*COLOR_W-1:0]   sphere_color,
  input  logic [N_SPHERES-1:0]           sphere_en,
  output logic                           busy,
  output logic                           done,
  output logic                           wr_en,
  output logic [$clog2(JOBS)-1:0]        wr_addr,
  output logic [COLOR_W-1:0]             wr_data
);
  localparam int AW = $clog2(JOBS);
  localparam int SW = N_SPHERES > 1 ? $clog2(N_SPHERES) : 1;
  localparam logic [4:0] L_LAST = 5'd31;
  localparam logic signed [63:0] PZ64 = 64'(PZ);
  localparam logic signed [63:0] ST64 = 64'(STRIDE);
  typedef enum logic [3:0] {IDLE, SETUP, DOT, DISC, SQ_GO, SQ_WAIT, CMP, WRITE, DONE_S} state_t;
  state_t state_q;
  logic busy_q, done_q, wr_en_q, bv_q;
  logic [AW-1:0] job_q, wr_addr_q;
  logic [SW-1:0] slot_q, nxt_slot;
  logic [COLOR_W-1:0] wr_data_q, bc_q, col_sel;
  logic [COORD_W-1:0] psx_q, py_q;
  logic [N_SPHERES*SPH_W-1:0] sx_q, sy_q, sz_q;
  logic [N_SPHERES*4-1:0] sr_q;
  logic [N_SPHERES*COLOR_W-1:0] sc_q;
  logic [N_SPHERES-1:0] en_q;
  logic signed [63:0] x_q, a_q, b_q, c_q, d_q, bn_q;
  logic signed [63:0] px, py, cx, cy, cz, x_c, r2, a_n, b_n, c_n, d_n, n_c;
  logic [SPH_W-1:0] fx, fy, fz;
  logic [3:0] fr;
  logic hit;
  logic sq_busy_q, ge;
  logic [4:0] sq_cnt_q;
  logic [63:0] rad_q, rem_q, root_q, rem_n, trial;
  assign busy = busy_q;
  assign done = done_q;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  // geometry for the current job and slot; the shared 2A denominator lets N be compared directly
  always_comb begin
    nxt_slot = slot_q + SW'(1);
    fx = sx_q[slot_q*SPH_W +: SPH_W];
    fy = sy_q[slot_q*SPH_W +: SPH_W];
    fz = sz_q[slot_q*SPH_W +: SPH_W];
    fr = sr_q[slot_q*4 +: 4];
    col_sel = sc_q[slot_q*COLOR_W +: COLOR_W];
    px = {{(64-COORD_W){psx_q[COORD_W-1]}}, psx_q};
    py = {{(64-COORD_W){py_q[COORD_W-1]}}, py_q};
    cx = {{(64-SPH_W){fx[SPH_W-1]}}, fx};
    cy = {{(64-SPH_W){fy[SPH_W-1]}}, fy};
    cz = {{(64-SPH_W){fz[SPH_W-1]}}, fz};
    x_c = px + {{(64-AW){1'b0}}, job_q} * ST64;
    r2 = 64'(1) << {fr, 1'b0};
    a_n = x_c * x_c + py * py + PZ64 * PZ64;
    b_n = (x_q * cx + py * cy + PZ64 * cz) <<< 1;
    c_n = cx * cx + cy * cy + cz * cz - r2;
    d_n = b_q * b_q - ((a_q * c_q) <<< 2);
    n_c = b_q - $signed(root_q);
    hit = en_q[slot_q] && !d_q[63] && !n_c[63] && n_c != 0 && (!bv_q || n_c < bn_q);
    rem_n = {rem_q[61:0], rad_q[63:62]};
    trial = {root_q[61:0], 2'b01};
    ge = rem_n >= trial;
  end
  // strip sequencer: latches the job, walks slots per pixel and emits writes and done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= BG_COLOR;
      job_q <= '0;
      slot_q <= '0;
      bv_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          psx_q <= pixel_start_x;
          py_q <= pixel_y;
          sx_q <= sphere_x;
          sy_q <= sphere_y;
          sz_q <= sphere_z;
          sr_q <= sphere_r;
          sc_q <= sphere_color;
          en_q <= sphere_en;
          busy_q <= 1'b1;
          state_q <= SETUP;
        end
        SETUP: begin
          x_q <= x_c;
          a_q <= a_n;
          bv_q <= 1'b0;
          slot_q <= '0;
          state_q <= en_q[0] ? DOT : CMP;
        end
        DOT: begin
          b_q <= b_n;
          c_q <= c_n;
          state_q <= DISC;
        end
        DISC: begin
          d_q <= d_n;
          state_q <= SQ_GO;
        end
        SQ_GO: state_q <= SQ_WAIT;
        SQ_WAIT: if (sq_cnt_q == 5'd0) state_q <= CMP;
        CMP: begin
          if (hit) begin
            bv_q <= 1'b1;
            bn_q <= n_c;
            bc_q <= col_sel;
          end
          if (slot_q == SW'(N_SPHERES-1)) begin
            wr_en_q <= 1'b1;
            wr_addr_q <= job_q;
            wr_data_q <= hit ? col_sel : bv_q ? bc_q : BG_COLOR;
            state_q <= WRITE;
          end else begin
            slot_q <= nxt_slot;
            state_q <= en_q[nxt_slot] ? DOT : CMP;
          end
        end
        WRITE: if (job_q == AW'(JOBS-1)) begin
          job_q <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state_q <= DONE_S;
        end else begin
          job_q <= job_q + AW'(1);
          state_q <= SETUP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // iterative floor square root, two radicand bits per cycle, 32 busy cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_busy_q <= 1'b0;
      sq_cnt_q <= '0;
      rad_q <= '0;
      rem_q <= '0;
      root_q <= '0;
    end else if (state_q == SQ_GO) begin
      sq_busy_q <= 1'b1;
      sq_cnt_q <= L_LAST;
      rad_q <= d_q;
      rem_q <= '0;
      root_q <= '0;
    end else if (sq_busy_q) begin
      rad_q <= rad_q << 2;
      rem_q <= ge ? rem_n - trial : rem_n;
      root_q <= {root_q[62:0], ge};
      sq_cnt_q <= sq_cnt_q - 5'd1;
      sq_busy_q <= sq_cnt_q != 5'd0;
    end
  end
endmodule

// File: tb/tb_ray_worker_multi.sv
// tb_ray_worker_multi: directed scenario tests for the multi-sphere ray worker
module tb_ray_worker_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [11:0] psx, py;
  logic [63:0] sx, sy, sz;
  logic [15:0] sr;
  logic [47:0] sc;
  logic [3:0] en;
  logic busy, done, wr_en;
  logic [5:0] wr_addr;
  logic [11:0] wr_data;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nw = 0;
  int nd = 0;
  logic [5:0] wa [2048];
  logic [11:0] wd [2048];
  int wc [2048];

  ray_worker_multi dut (
    .clk(clk), .rst(rst), .start(start), .pixel_start_x(psx), .pixel_y(py),
    .sphere_x(sx), .sphere_y(sy), .sphere_z(sz), .sphere_r(sr), .sphere_color(sc),
    .sphere_en(en), .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1 && nw < 2048) begin
      wa[nw] = wr_addr;
      wd[nw] = wr_data;
      wc[nw] = cyc;
      nw++;
    end
    if (done === 1'b1) nd++;
  end

  task automatic clear_spheres;
    psx = '0; py = '0; sx = '0; sy = '0; sz = '0; sr = '0; sc = '0; en = '0;
  endtask

  task automatic set_sphere(input int i, input int x, input int y, input int z, input int r, input logic [11:0] col);
    sx[i*16 +: 16] = 16'(x);
    sy[i*16 +: 16] = 16'(y);
    sz[i*16 +: 16] = 16'(z);
    sr[i*4 +: 4] = 4'(r);
    sc[i*12 +: 12] = col;
    en[i] = 1'b1;
  endtask

  task automatic run_strip(input bit disturb, output int c0, output int cd, output logic b0, output logic bd);
    bit seen;
    seen = 0; cd = 0; bd = 1'bx;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c0 = cyc; b0 = busy;
    for (int k = 0; k < 20000 && !seen; k++) begin
      if (disturb && k == 100) begin
        start = 1'b1;
        sz[15:0] = 16'hFD80;
        en = 4'hF;
        sc = ~sc;
        psx = 12'd500;
      end
      if (disturb && k == 101) start = 1'b0;
      @(posedge clk); #1;
      if (done === 1'b1) begin seen = 1; cd = cyc; bd = busy; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL strip_timeout done=0 required=1"); end
  endtask

  task automatic test_reset;
    clear_spheres;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++; if (wr_addr !== 6'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
    checks++; if (wr_data !== 12'h000) begin failures++; $display("FAIL reset_wr_data got=%h exp=000", wr_data); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    int b, n0, c0, cd, bad;
    logic b0, bd;
    clear_spheres;
    set_sphere(0, 0, 0, 640, 6, 12'hF00);
    b = nw; n0 = nd;
    run_strip(0, c0, cd, b0, bd);
    repeat (3) @(posedge clk);
    #2;
    checks++; if (nw - b != 64) begin failures++; $display("FAIL single_count got=%0d exp=64", nw - b); end
    checks++; if (wd[b] !== 12'hF00) begin failures++; $display("FAIL single_job0 got=%h exp=F00", wd[b]); end
    checks++; if (wd[b+3] !== 12'hF00) begin failures++; $display("FAIL single_job3 got=%h exp=F00", wd[b+3]); end
    checks++; if (wd[b+4] !== 12'h000) begin failures++; $display("FAIL single_job4 got=%h exp=000", wd[b+4]); end
    checks++; if (wd[b+10] !== 12'h000) begin failures++; $display("FAIL single_job10 got=%h exp=000", wd[b+10]); end
    checks++; if (wc[b] - c0 != 40) begin failures++; $display("FAIL single_first_latency got=%0d exp=40", wc[b] - c0); end
    bad = 0;
    for (int k = 1; k < 64; k++) if (wc[b+k] - wc[b+k-1] != 41) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL single_period bad=%0d exp=0 (41 cycles)", bad); end
    checks++; if (cd - wc[b+63] != 1) begin failures++; $display("FAIL single_done_delay got=%0d exp=1", cd - wc[b+63]); end
    checks++; if (nd - n0 != 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", nd - n0); end
  endtask

  task automatic test_nearest;
    int b, c0, cd;
    logic b0, bd;
    clear_spheres;
    set_sphere(0, 0, 0, 1280, 6, 12'hF00);
    set_sphere(1, 0, 0, 640, 6, 12'h0F0);
    b = nw;
    run_strip(0, c0, cd, b0, bd);
    repeat (3) @(posedge clk);
    #2;
    checks++; if (wd[b] !== 12'h0F0) begin failures++; $display("FAIL nearest_job0 got=%h exp=0F0", wd[b]); end
    checks++; if (wd[b+2] !== 12'h0F0) begin failures++; $display("FAIL nearest_job2 got=%h exp=0F0", wd[b+2]); end
    checks++; if (wd[b+4] !== 12'h000) begin failures++; $display("FAIL nearest_job4 got=%h exp=000", wd[b+4]); end
    checks++; if (wc[b+1] - wc[b] != 76) begin failures++; $display("FAIL nearest_period got=%0d exp=76", wc[b+1] - wc[b]); end
  endtask

  task automatic test_tie;
    int b, c0, cd;
    logic b0, bd;
    clear_spheres;
    set_sphere(0, 0, 0, 640, 6, 12'h00F);
    set_sphere(1, 0, 0, 640, 6, 12'hFF0);
    b = nw;
    run_strip(0, c0, cd, b0, bd);
    repeat (3) @(posedge clk);
    #2;
    checks++; if (wd[b] !== 12'h00F) begin failures++; $display("FAIL tie_job0 got=%h exp=00F", wd[b]); end
    checks++; if (wd[b+3] !== 12'h00F) begin failures++; $display("FAIL tie_job3 got=%h exp=00F", wd[b+3]); end
  endtask

  task automatic test_behind;
    int b, n0, c0, cd, bad;
    logic b0, bd;
    clear_spheres;
    set_sphere(0, 0, 0, -640, 6, 12'hF00);
    b = nw; n0 = nd;
    run_strip(0, c0, cd, b0, bd);
    repeat (50) @(posedge clk);
    #2;
    bad = 0;
    for (int k = 0; k < 64; k++) if (wd[b+k] !== 12'h000) bad++;
    checks++; if (nw - b != 64) begin failures++; $display("FAIL behind_count got=%0d exp=64", nw - b); end
    checks++; if (bad != 0) begin failures++; $display("FAIL behind_bg bad=%0d exp=0", bad); end
    checks++; if (nd - n0 != 1) begin failures++; $display("FAIL behind_done_count got=%0d exp=1", nd - n0); end
  endtask

  task automatic test_protocol;
    int b, n0, c0, cd, bad;
    logic b0, bd;
    clear_spheres;
    set_sphere(0, 0, 0, 640, 6, 12'hF00);
    b = nw; n0 = nd;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL proto_idle_busy got=%b exp=0", busy); end
    run_strip(1, c0, cd, b0, bd);
    repeat (3) @(posedge clk);
    #2;
    checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL proto_busy_rise got=%b exp=1", b0); end
    checks++; if (bd !== 1'b0) begin failures++; $display("FAIL proto_busy_at_done got=%b exp=0", bd); end
    checks++; if (nw - b != 64) begin failures++; $display("FAIL proto_count got=%0d exp=64", nw - b); end
    bad = 0;
    for (int k = 0; k < 64; k++) if (wa[b+k] !== 6'(k)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL proto_addr_order bad=%0d exp=0", bad); end
    bad = 0;
    for (int k = 1; k < 64; k++) if (wc[b+k] - wc[b+k-1] != 41) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL proto_period bad=%0d exp=0 (41 cycles)", bad); end
    checks++; if (wd[b] !== 12'hF00) begin failures++; $display("FAIL proto_job0 got=%h exp=F00", wd[b]); end
    checks++; if (wd[b+3] !== 12'hF00) begin failures++; $display("FAIL proto_job3 got=%h exp=F00", wd[b+3]); end
    checks++; if (wd[b+10] !== 12'h000) begin failures++; $display("FAIL proto_job10 got=%h exp=000", wd[b+10]); end
    checks++; if (cd - wc[b+63] != 1) begin failures++; $display("FAIL proto_done_delay got=%0d exp=1", cd - wc[b+63]); end
    checks++; if (nd - n0 != 1) begin failures++; $display("FAIL proto_done_count got=%0d exp=1", nd - n0); end
  endtask

  task automatic test_reset_mid;
    int b, n0, c0, cd, bad;
    logic b0, bd;
    bit seen;
    clear_spheres;
    set_sphere(0, 0, 0, 640, 6, 12'hF00);
    b = nw; n0 = nd; seen = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(posedge clk); #2;
      if (nw >= b + 5) seen = 1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rmid_wait got=%0d exp=5 writes", nw - b); end
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rmid_done got=%b exp=0", done); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rmid_wr_en got=%b exp=0", wr_en); end
    checks++; if (wr_addr !== 6'd0) begin failures++; $display("FAIL rmid_wr_addr got=%0d exp=0", wr_addr); end
    checks++; if (wr_data !== 12'h000) begin failures++; $display("FAIL rmid_wr_data got=%h exp=000", wr_data); end
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    checks++; if (nw - b != 5) begin failures++; $display("FAIL rmid_no_write got=%0d exp=5", nw - b); end
    checks++; if (nd != n0) begin failures++; $display("FAIL rmid_no_done got=%0d exp=%0d", nd, n0); end
    b = nw;
    run_strip(0, c0, cd, b0, bd);
    repeat (3) @(posedge clk);
    #2;
    bad = 0;
    for (int k = 0; k < 64; k++) if (wa[b+k] !== 6'(k)) bad++;
    checks++; if (nw - b != 64) begin failures++; $display("FAIL rmid_restart_count got=%0d exp=64", nw - b); end
    checks++; if (bad != 0) begin failures++; $display("FAIL rmid_restart_order bad=%0d exp=0", bad); end
    checks++; if (wd[b] !== 12'hF00) begin failures++; $display("FAIL rmid_restart_job0 got=%h exp=F00", wd[b]); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_nearest;
    test_tie;
    test_behind;
    test_protocol;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
